// File: rtl/pd_iso_pkg.sv
// Shared types and constants for the power-domain isolation sequencer.
// Each state maps to one registered output pattern through PD_OUT.
package pd_iso_pkg;

    localparam int DEF_SETTLE_CYCLES = 4;
    localparam int DEF_PSW_TIMEOUT   = 1023;

    typedef enum logic [3:0] {
        ST_ON,
        ST_CLK_STOP,
        ST_ISO_ON,
        ST_RST_ASSERT,
        ST_PSW_OFF,
        ST_OFF,
        ST_PSW_ON,
        ST_RST_RELEASE,
        ST_CLK_RUN,
        ST_ISO_OFF
    } pd_state_e;

    typedef struct packed {
        logic psw_en;
        logic iso_en;
        logic clk_en;
        logic rst_dom_n;
        logic sleep_ack;
    } pd_out_t;

    // Indexed by pd_state_e; entry order must follow the enum encoding.
    localparam pd_out_t PD_OUT [10] = '{
        '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0},
        '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0},
        '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0},
        '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0},
        '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0},
        '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1},
        '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1},
        '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1},
        '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1},
        '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1}
    };

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic is_timed(input pd_state_e s);
        return (s == ST_CLK_STOP) || (s == ST_ISO_ON) || (s == ST_RST_ASSERT) ||
               (s == ST_RST_RELEASE) || (s == ST_CLK_RUN) || (s == ST_ISO_OFF);
    endfunction

    function automatic pd_state_e next_step(input pd_state_e s);
        pd_state_e n;
        case (s)
            ST_CLK_STOP:    n = ST_ISO_ON;
            ST_ISO_ON:      n = ST_RST_ASSERT;
            ST_RST_ASSERT:  n = ST_PSW_OFF;
            ST_PSW_OFF:     n = ST_OFF;
            ST_PSW_ON:      n = ST_RST_RELEASE;
            ST_RST_RELEASE: n = ST_CLK_RUN;
            ST_CLK_RUN:     n = ST_ISO_OFF;
            default:        n = ST_ON;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/pd_iso_if.sv
// Boundary signals between the sequencer and the switchable domain's
// power switch, isolation cells, clock gate and reset.
interface pd_iso_if;

    logic sleep_req_i;
    logic sleep_ack_o;
    logic psw_en_o;
    logic psw_ack_i;
    logic iso_en_o;
    logic clk_en_o;
    logic rst_dom_no;
    logic err_o;

    modport master (
        input  sleep_req_i,
        input  psw_ack_i,
        output sleep_ack_o,
        output psw_en_o,
        output iso_en_o,
        output clk_en_o,
        output rst_dom_no,
        output err_o
    );

    modport slave (
        output sleep_req_i,
        output psw_ack_i,
        input  sleep_ack_o,
        input  psw_en_o,
        input  iso_en_o,
        input  clk_en_o,
        input  rst_dom_no,
        input  err_o
    );

endinterface

// File: rtl/pd_sync_2ff.sv
// Two-flop synchronizer with a configurable reset value.
module pd_sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d,
    output logic q
);

    logic ff1;
    logic ff2;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ff1 <= RESET_VAL;
            ff2 <= RESET_VAL;
        end else begin
            ff1 <= d;
            ff2 <= ff1;
        end
    end

    assign q = ff2;

endmodule

// File: rtl/pd_iso_sequencer.sv
// Sleep/wake sequencer for a switchable power domain: orders clock gating,
// isolation, domain reset and the power switch so isolation brackets every unsafe step.
module pd_iso_sequencer
    import pd_iso_pkg::*;
#(
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int PSW_TIMEOUT   = DEF_PSW_TIMEOUT
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    pd_iso_if.master  pd
);

    localparam int CNT_W = $clog2(max_int(SETTLE_CYCLES, PSW_TIMEOUT) + 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(PSW_TIMEOUT - 1);

    pd_state_e        state_q;
    pd_state_e        state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             err_q;
    logic             err_d;
    pd_out_t          out_q;
    logic             ack_sync;
    logic             ack_want;

    pd_sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_ack_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d      (pd.psw_ack_i),
        .q      (ack_sync)
    );

    assign ack_want = (state_q == ST_PSW_ON);

    // One counter serves both purposes: down-count in timed states, up-count as the switch timeout.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            ST_ON: begin
                if (pd.sleep_req_i) state_d = ST_CLK_STOP;
            end
            ST_OFF: begin
                if (!pd.sleep_req_i) state_d = ST_PSW_ON;
            end
            ST_PSW_OFF, ST_PSW_ON: begin
                if (ack_sync == ack_want) begin
                    state_d = next_step(state_q);
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = next_step(state_q);
                    err_d   = 1'b1;
                end
            end
            default: begin
                if (cnt_q == '0) state_d = next_step(state_q);
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = is_timed(state_d) ? SETTLE_LOAD : '0;
        end else if (is_timed(state_q)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else if ((state_q == ST_PSW_OFF) || (state_q == ST_PSW_ON)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Outputs are decoded from the next state so they switch on the edge entering a state.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_ON;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            out_q   <= PD_OUT[ST_ON];
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            out_q   <= PD_OUT[state_d];
        end
    end

    assign pd.psw_en_o    = out_q.psw_en;
    assign pd.iso_en_o    = out_q.iso_en;
    assign pd.clk_en_o    = out_q.clk_en;
    assign pd.rst_dom_no  = out_q.rst_dom_n;
    assign pd.sleep_ack_o = out_q.sleep_ack;
    assign pd.err_o       = err_q;

endmodule
